// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and flag controller for a single-clock FWFT FIFO.
// The attached memory writes on mem_wen at mem_waddr and reads combinationally at mem_raddr.
module sync_fifo_ctrl #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic             mem_wen,
  output logic [ASIZE-1:0] mem_waddr,
  output logic [ASIZE-1:0] mem_raddr,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = ASIZE + 1;

  // Reject parameter sets that would make the thresholds meaningless.
  if (DSIZE < 1 || AFULL_TH < 1 || AFULL_TH >= DEPTH ||
      AEMPTY_TH < 1 || AEMPTY_TH >= DEPTH) begin : g_bad_params
    $error("sync_fifo_ctrl: threshold or width parameter out of range");
  end

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] wptr_nxt, rptr_nxt, count_nxt;
  logic          wr_acc, rd_acc;
  logic          full_nxt, empty_nxt, afull_nxt, aempty_nxt;
  logic          overflow_nxt, underflow_nxt;

  // Next-state: flags come from the next count so they always agree with it.
  always_comb begin
    wr_acc        = wr_en & ~full;
    rd_acc        = rd_en & ~empty;
    wptr_nxt      = wptr + PW'(wr_acc);
    rptr_nxt      = rptr + PW'(rd_acc);
    count_nxt     = count + PW'(wr_acc) - PW'(rd_acc);
    full_nxt      = (count_nxt == PW'(DEPTH));
    empty_nxt     = (count_nxt == '0);
    afull_nxt     = (count_nxt >= PW'(AFULL_TH));
    aempty_nxt    = (count_nxt <= PW'(AEMPTY_TH));
    // A fresh error event outranks a simultaneous clear.
    overflow_nxt  = (wr_en & full)  | (overflow  & ~clr_err);
    underflow_nxt = (rd_en & empty) | (underflow & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      count        <= count_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= afull_nxt;
      almost_empty <= aempty_nxt;
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

  // Write strobe is combinational so the memory captures in the accepting cycle.
  assign mem_wen   = wr_en & ~full & ~rst;
  assign mem_waddr = wptr[ASIZE-1:0];
  assign mem_raddr = rptr[ASIZE-1:0];

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (ASIZE=4, AFULL_TH=14, AEMPTY_TH=2).
module tb_sync_fifo_ctrl;

  logic       clk, rst, wr_en, rd_en, clr_err;
  logic       mem_wen, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] mem_waddr, mem_raddr;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  // {count, full, empty, almost_full, almost_empty, overflow, underflow}
  logic [10:0] obs;
  logic [10:0] exp_v;
  assign obs = {count, full, empty, almost_full, almost_empty, overflow, underflow};

  logic [7:0] mem_model [16];
  int         tagq [$];
  int         tag;

  sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; clr_err = 1'b1;
    step(); step();
    exp_v = {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_flags got %b want %b", obs, exp_v); end
    checks++;
    if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen got %b want 0", mem_wen); end
    checks++;
    if ({mem_waddr, mem_raddr} !== 8'h00) begin
      errors++; $display("FAIL reset_addr got %h/%h want 0/0", mem_waddr, mem_raddr);
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #1;
      checks++;
      if ({mem_wen, mem_waddr} !== {1'b1, 4'(i)}) begin
        errors++; $display("FAIL fill_wr[%0d] got wen=%b addr=%0d want wen=1 addr=%0d", i, mem_wen, mem_waddr, i);
      end
      step();
      exp_v = {5'(i + 1), (i + 1 == 16), 1'b0, (i + 1 >= 14), (i + 1 <= 2), 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL fill_flags[%0d] got %b want %b", i, obs, exp_v); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    wr_en = 1'b1; rd_en = 1'b0;
    #1;
    checks++;
    if (mem_wen !== 1'b0) begin errors++; $display("FAIL ovf_mem_wen got %b want 0", mem_wen); end
    step();
    exp_v = {5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ovf_set got %b want %b", obs, exp_v); end
    clr_err = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_event got %b want 1", overflow); end
    wr_en = 1'b0;
    step();
    clr_err = 1'b0;
    exp_v = {5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ovf_clear got %b want %b", obs, exp_v); end
  endtask

  task automatic test_full_rw();
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    checks++;
    if ({mem_wen, mem_raddr} !== 5'b0_0000) begin
      errors++; $display("FAIL full_rw_pre got wen=%b raddr=%0d want wen=0 raddr=0", mem_wen, mem_raddr);
    end
    step();
    exp_v = {5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL full_rw_flags got %b want %b", obs, exp_v); end
    checks++;
    if ({mem_waddr, mem_raddr} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL full_rw_ptrs got w=%0d r=%0d want w=0 r=1", mem_waddr, mem_raddr);
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic test_drain();
    for (int c = 14; c >= 0; c--) begin
      rd_en = 1'b1;
      step();
      exp_v = {5'(c), 1'b0, (c == 0), (c >= 14), (c <= 2), 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL drain_flags[%0d] got %b want %b", c, obs, exp_v); end
    end
    rd_en = 1'b0;
    checks++;
    if (mem_raddr !== 4'd0) begin errors++; $display("FAIL drain_raddr got %0d want 0", mem_raddr); end
  endtask

  task automatic test_underflow();
    wr_en = 1'b1; rd_en = 1'b1;
    #1;
    checks++;
    if ({mem_wen, mem_waddr} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL unf_pre got wen=%b waddr=%0d want wen=1 waddr=0", mem_wen, mem_waddr);
    end
    step();
    exp_v = {5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL unf_flags got %b want %b", obs, exp_v); end
    checks++;
    if ({mem_waddr, mem_raddr} !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL unf_ptrs got w=%0d r=%0d want w=1 r=0", mem_waddr, mem_raddr);
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; step(); rst = 1'b0;
    tag = 0;
    tagq.delete();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      #1;
      if (mem_wen) mem_model[mem_waddr] = 8'(tag);
      tagq.push_back(tag);
      tag++;
      step();
    end
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; rd_en = 1'b1;
      #1;
      checks++;
      if (int'(mem_model[mem_raddr]) !== tagq[0]) begin
        errors++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, mem_model[mem_raddr], tagq[0]);
      end
      void'(tagq.pop_front());
      if (mem_wen) mem_model[mem_waddr] = 8'(tag);
      tagq.push_back(tag);
      tag++;
      step();
      exp_v = {5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL b2b_flags[%0d] got %b want %b", i, obs, exp_v); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if ({mem_waddr, mem_raddr} !== {4'd13, 4'd8}) begin
      errors++; $display("FAIL b2b_wrap got w=%0d r=%0d want w=13 r=8", mem_waddr, mem_raddr);
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1; step(); rst = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (count !== 5'd9) begin errors++; $display("FAIL arst_prefill got %0d want 9", count); end
    #2 rst = 1'b1;
    #1;
    exp_v = {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL arst_flags got %b want %b", obs, exp_v); end
    checks++;
    if ({mem_wen, mem_waddr, mem_raddr} !== 9'd0) begin
      errors++; $display("FAIL arst_ptrs got wen=%b w=%0d r=%0d want 0/0/0", mem_wen, mem_waddr, mem_raddr);
    end
    step();
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL arst_hold got %0d want 0", count); end
    rst = 1'b0; wr_en = 1'b0;
    step();
    checks++;
    if ({count, empty} !== {5'd0, 1'b1}) begin
      errors++; $display("FAIL arst_release got count=%0d empty=%b want 0/1", count, empty);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data width of the attached FIFO memory (informational; no data passes through this block).
REQ-002 SHALL have parameter ASIZE, default 4, address width; DEPTH = 2**ASIZE.
REQ-003 SHALL have parameter AFULL_TH, default 14, almost-full threshold in entries, range 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold in entries, range 1..DEPTH-1.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port rd_en  input  1  read request (pop).
REQ-009 SHALL have port clr_err  input  1  synchronous clear of the sticky error flags.
REQ-010 SHALL have port mem_wen  output  1  memory write enable, combinational = wr_en & ~full.
REQ-011 SHALL have port mem_waddr  output  ASIZE  memory write address = wptr[ASIZE-1:0].
REQ-012 SHALL have port mem_raddr  output  ASIZE  memory read address = rptr[ASIZE-1:0].
REQ-013 SHALL have port full  output  1  registered; FIFO holds DEPTH entries; also drives the memory wfull input.
REQ-014 SHALL have port empty  output  1  registered; FIFO holds 0 entries.
REQ-015 SHALL have port almost_full  output  1  registered; count >= AFULL_TH.
REQ-016 SHALL have port almost_empty  output  1  registered; count <= AEMPTY_TH.
REQ-017 SHALL have port count  output  ASIZE+1  registered occupancy, 0..DEPTH.
REQ-018 SHALL have port overflow  output  1  sticky; a write was attempted while full.
REQ-019 SHALL have port underflow  output  1  sticky; a read was attempted while empty.

Function
REQ-020 SHALL keep wptr and rptr as ASIZE+1-bit binary counters, wrapping modulo 2**(ASIZE+1).
REQ-021 SHALL accept a write (wptr+1) iff wr_en=1 and full=0, in the same cycle that mem_wen=1.
REQ-022 SHALL accept a read (rptr+1) iff rd_en=1 and empty=0.
REQ-023 SHALL make read data first-word-fall-through: while empty=0, the memory's combinational output at mem_raddr is the head entry; an accepted read advances it after the edge.
REQ-024 SHALL update count: +1 on write only, -1 on read only, unchanged on both-accepted or neither.
REQ-025 SHALL compute full, empty, almost_full and almost_empty from the next-state count and register them, so all flags are consistent with count in every cycle.
REQ-026 SHALL, when full=1 and wr_en=rd_en=1, accept the read, reject the write and set overflow; full deasserts next cycle.
REQ-027 SHALL, when empty=1 and wr_en=rd_en=1, accept the write, reject the read and set underflow; empty deasserts next cycle.
REQ-028 SHALL keep full=1 and empty=1 mutually exclusive; full iff wptr and rptr differ only in the MSB; empty iff wptr == rptr.
REQ-029 SHALL show write latency of one edge: a write accepted at edge N makes empty=0 and the entry readable from cycle N+1.
REQ-030 SHALL hold overflow/underflow until clr_err=1; clr_err clears on the next edge, and a new error event in the same cycle as clr_err SHALL win (flag stays 1).
REQ-031 SHALL make the pointer MSB wrap transparent: full/empty/count stay correct across any number of wraps.

Reset
REQ-032 SHALL, on rst=1, immediately and asynchronously set wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-033 SHALL ignore wr_en, rd_en and clr_err while rst=1; mem_wen SHALL be 0 during reset; reset mid-operation discards all contents.

Verification (ASIZE=4, AFULL_TH=14, AEMPTY_TH=2)
REQ-034 SHALL cover: reset then 16 consecutive writes -> count 1..16, almost_empty=0 after count=3, almost_full=1 at count=14, full=1 at count=16, mem_waddr 0..15.
REQ-035 SHALL cover: full, 17th write with rd_en=0 -> mem_wen=0, count stays 16, overflow=1; clr_err pulse -> overflow=0 next cycle.
REQ-036 SHALL cover: full, wr_en=rd_en=1 -> count 15, full=0, rptr+1, wptr unchanged, overflow=1.
REQ-037 SHALL cover: empty, wr_en=rd_en=1 -> count 1, empty=0, underflow=1, mem_raddr unchanged.
REQ-038 SHALL cover: 40 write/read pairs at count 5 -> count stays 5, pointers wrap twice, flags unchanged, data order preserved.
REQ-039 SHALL cover: rst asserted asynchronously mid-cycle at count 9 -> count=0, empty=1, pointers 0 before next clk edge.
